// File: rtl/bbox_msg_reader.sv
`default_nettype none
// ============================================================================
// bbox_msg_reader : Avalon-MM master draining the bounding-box message FIFO
// Optional feature: BBOX_EMPTY_FILTER_EN drops empty (min > max) boxes.
// Revision: 1.0
// ============================================================================
module bbox_msg_reader #(
   parameter int unsigned POLL_INTERVAL = 64,
   parameter logic [31:0] EXPECTED_ID   = 32'h1234EEE2,
   parameter logic [31:0] MSG_ID        = 32'h00524242
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        m_chipselect,
   output logic        m_read,
   output logic        m_write,
   output logic [2:0]  m_address,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        bb_valid,
   output logic [10:0] bb_x_min,
   output logic [10:0] bb_y_min,
   output logic [10:0] bb_x_max,
   output logic [10:0] bb_y_max,
   output logic [15:0] bb_count,
   output logic [7:0]  sync_err_count,
   output logic        id_error
);

   localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_INTERVAL - 1);

   typedef enum logic [3:0] {
      ID_RD, ID_CAP, FLUSH, POLL_WAIT, STAT_RD, STAT_CAP, HDR_RD, HDR_CAP,
      TL_RD, TL_CAP, BR_RD, BR_CAP, DELIVER, ERROR
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] poll_cnt;
   logic [10:0]      sh_x_min, sh_y_min, sh_x_max, sh_y_max;
   logic             deliver_ok;

`ifdef BBOX_EMPTY_FILTER_EN
   assign deliver_ok = !((sh_x_min > sh_x_max) || (sh_y_min > sh_y_max));
`else
   assign deliver_ok = 1'b1;
`endif

   // Bus strobes decode straight from the state register so the ID read lands in
   // the very first cycle out of reset; reset masks them so any access aborts at once.
   always_comb begin
      m_chipselect = 1'b0;
      m_read       = 1'b0;
      m_write      = 1'b0;
      m_address    = 3'd0;
      m_writedata  = 32'h0;
      if (!reset) begin
         case (state)
            ID_RD: begin
               m_chipselect = 1'b1;
               m_read       = 1'b1;
               m_address    = 3'd2;
            end
            FLUSH: begin
               m_chipselect = 1'b1;
               m_write      = 1'b1;
               m_writedata  = 32'h0000_0010;
            end
            STAT_RD: begin
               m_chipselect = 1'b1;
               m_read       = 1'b1;
            end
            HDR_RD, TL_RD, BR_RD: begin
               m_chipselect = 1'b1;
               m_read       = 1'b1;
               m_address    = 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ID_RD;
         poll_cnt       <= '0;
         sh_x_min       <= '0;
         sh_y_min       <= '0;
         sh_x_max       <= '0;
         sh_y_max       <= '0;
         bb_valid       <= 1'b0;
         bb_x_min       <= '0;
         bb_y_min       <= '0;
         bb_x_max       <= '0;
         bb_y_max       <= '0;
         bb_count       <= '0;
         sync_err_count <= '0;
         id_error       <= 1'b0;
      end else begin
         bb_valid <= 1'b0;
         case (state)
            ID_RD:  state <= ID_CAP;
            ID_CAP: begin
               if (m_readdata != EXPECTED_ID) begin
                  state    <= ERROR;
                  id_error <= 1'b1;
               end else begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               state    <= POLL_WAIT;
               poll_cnt <= POLL_LOAD;
            end
            POLL_WAIT: begin
               if (poll_cnt != '0)
                  poll_cnt <= poll_cnt - CNT_W'(1);
               else if (enable)
                  state <= STAT_RD;
            end
            STAT_RD:  state <= STAT_CAP;
            STAT_CAP: begin
               if (m_readdata[15:8] >= 8'd3) begin
                  state <= HDR_RD;
               end else begin
                  state    <= POLL_WAIT;
                  poll_cnt <= POLL_LOAD;
               end
            end
            HDR_RD:  state <= HDR_CAP;
            HDR_CAP: begin
               if (m_readdata == MSG_ID) begin
                  state <= TL_RD;
               end else begin
                  // Drop one word per pass until a header lines up again.
                  if (sync_err_count != 8'hFF)
                     sync_err_count <= sync_err_count + 8'd1;
                  state <= STAT_RD;
               end
            end
            TL_RD:  state <= TL_CAP;
            TL_CAP: begin
               sh_x_min <= m_readdata[26:16];
               sh_y_min <= m_readdata[10:0];
               state    <= BR_RD;
            end
            BR_RD:  state <= BR_CAP;
            BR_CAP: begin
               sh_x_max <= m_readdata[26:16];
               sh_y_max <= m_readdata[10:0];
               state    <= DELIVER;
            end
            DELIVER: begin
               if (deliver_ok) begin
                  bb_x_min <= sh_x_min;
                  bb_y_min <= sh_y_min;
                  bb_x_max <= sh_x_max;
                  bb_y_max <= sh_y_max;
                  bb_valid <= 1'b1;
                  bb_count <= bb_count + 16'd1;
               end
               state <= STAT_RD;
            end
            ERROR:   state <= ERROR;
            default: state <= ID_RD;
         endcase
      end
   end

endmodule
`default_nettype wire
